// File: rtl/dm_pkg.sv
// Shared types, constants and helpers for the banked data-memory front-end.
package dm_pkg;

   localparam int unsigned MAX_BYTES = 64;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // Levels driven onto a bank that is not addressed this cycle.
   localparam logic IDLE_CEB  = 1'b1;
   localparam logic IDLE_WEB  = 1'b1;
   localparam logic IDLE_BWEB = 1'b1;
   localparam logic IDLE_A    = 1'b0;
   localparam logic IDLE_DI   = 1'b0;

   function automatic int unsigned bsel_w(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++)
         if ((32'd1 << i) < n) r = i + 1;
      return r;
   endfunction

   function automatic logic [MAX_BYTES*8-1:0] strb_to_bweb(input logic [MAX_BYTES-1:0] strb);
      logic [MAX_BYTES*8-1:0] r;
      r = '1;
      for (int unsigned k = 0; k < MAX_BYTES; k++)
         r[k*8 +: 8] = strb[k] ? 8'h00 : 8'hFF;
      return r;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order read-response buffer: circular store with explicit pointer wrap.
module resp_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [DATA_W-1:0]          dout
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;
   logic [PTR_W-1:0]  w_wr_nxt;
   logic [PTR_W-1:0]  w_rd_nxt;

   // Depth need not be a power of two, so wrap on an explicit compare.
   assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         assert (!(push && !pop && (r_cnt == CNT_W'(DEPTH))));
         if (push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= w_wr_nxt;
         end
         if (pop) r_rd_ptr <= w_rd_nxt;
         case ({push, pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign count = r_cnt;
   assign dout  = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/dm_bank_ctrl.sv
// Data-memory front-end: word-interleaved SRAM banks behind a valid/ready
// request channel with a buffered, in-order read-response channel.
module dm_bank_ctrl
   import dm_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic                                                     req_valid,
   output logic                                                     req_ready,
   input  logic                                                     req_we,
   input  logic [ADDR_W-1:0]                                        req_addr,
   input  logic [DATA_W/8-1:0]                                      req_wstrb,
   input  logic [DATA_W-1:0]                                        req_wdata,
   output logic                                                     resp_valid,
   input  logic                                                     resp_ready,
   output logic [DATA_W-1:0]                                        resp_rdata,
   output logic [NUM_BANKS-1:0]                                     bank_ceb,
   output logic [NUM_BANKS-1:0]                                     bank_web,
   output logic [NUM_BANKS-1:0][DATA_W-1:0]                         bank_bweb,
   output logic [NUM_BANKS-1:0][ADDR_W-bsel_w(NUM_BANKS)-1:0]       bank_a,
   output logic [NUM_BANKS-1:0][DATA_W-1:0]                         bank_di,
   input  logic [NUM_BANKS-1:0][DATA_W-1:0]                         bank_do
);

   localparam int unsigned BSEL_W = bsel_w(NUM_BANKS);
   localparam int unsigned ROW_W  = ADDR_W - BSEL_W;
   localparam int unsigned BIDX_W = (BSEL_W == 0) ? 1 : BSEL_W;
   localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);

   logic [BIDX_W-1:0]        w_bank;
   logic [ROW_W-1:0]         w_row;
   logic [MAX_BYTES*8-1:0]   w_bweb_full;
   logic [DATA_W-1:0]        w_bweb;
   logic                     w_acc;
   logic                     w_pop;
   logic [CNT_W-1:0]         w_count;
   logic [CNT_W:0]           w_occ;
   op_e                      w_op;
   logic                     r_pend_v;
   logic [BIDX_W-1:0]        r_pend_bank;

   generate
      if (BSEL_W == 0) begin : g_one_bank
         assign w_bank = '0;
      end else begin : g_multi_bank
         assign w_bank = req_addr[BSEL_W-1:0];
      end
   endgenerate

   assign w_row       = req_addr[ADDR_W-1:BSEL_W];
   assign w_op        = op_e'(req_we);
   assign w_bweb_full = strb_to_bweb(MAX_BYTES'(req_wstrb));
   assign w_bweb      = w_bweb_full[DATA_W-1:0];
   assign w_acc       = req_valid & req_ready;
   assign w_pop       = resp_valid & resp_ready;

   // Count the in-flight read as occupied so its push can never overflow.
   assign w_occ     = {1'b0, w_count} + (CNT_W+1)'(r_pend_v) - (CNT_W+1)'(w_pop);
   assign req_ready = !rst && (w_occ < (CNT_W+1)'(RESP_DEPTH));

   always_comb begin
      bank_ceb  = {NUM_BANKS{IDLE_CEB}};
      bank_web  = {NUM_BANKS{IDLE_WEB}};
      bank_bweb = {NUM_BANKS{{DATA_W{IDLE_BWEB}}}};
      bank_a    = {NUM_BANKS{{ROW_W{IDLE_A}}}};
      bank_di   = {NUM_BANKS{{DATA_W{IDLE_DI}}}};
      if (w_acc) begin
         if (w_op == OP_WRITE) begin
            if (|req_wstrb) begin
               bank_ceb[w_bank]  = 1'b0;
               bank_web[w_bank]  = 1'b0;
               bank_bweb[w_bank] = w_bweb;
               bank_a[w_bank]    = w_row;
               bank_di[w_bank]   = req_wdata;
            end
         end else begin
            bank_ceb[w_bank] = 1'b0;
            bank_a[w_bank]   = w_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_v    <= 1'b0;
         r_pend_bank <= '0;
      end else begin
         r_pend_v <= w_acc && (w_op == OP_READ);
         if (w_acc) r_pend_bank <= w_bank;
      end
   end

   resp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RESP_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_pend_v),
      .pop   (w_pop),
      .din   (bank_do[r_pend_bank]),
      .count (w_count),
      .dout  (resp_rdata)
   );

   assign resp_valid = (w_count != '0);

endmodule

// File: tb/tb_dm_bank_ctrl.sv
// Directed and randomized checks of dm_bank_ctrl against a word-level memory
// and response-queue reference model, with behavioural SRAM banks attached.
module tb_dm_bank_ctrl;

   localparam int NB = 4;
   localparam int DW = 32;
   localparam int AW = 14;
   localparam int RD = 2;
   localparam int RW = 12;

   logic                    clk;
   logic                    rst;
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [AW-1:0]           req_addr;
   logic [DW/8-1:0]         req_wstrb;
   logic [DW-1:0]           req_wdata;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [DW-1:0]           resp_rdata;
   logic [NB-1:0]           bank_ceb;
   logic [NB-1:0]           bank_web;
   logic [NB-1:0][DW-1:0]   bank_bweb;
   logic [NB-1:0][RW-1:0]   bank_a;
   logic [NB-1:0][DW-1:0]   bank_di;
   logic [NB-1:0][DW-1:0]   bank_do;

   dm_bank_ctrl #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .NUM_BANKS  (NB),
      .RESP_DEPTH (RD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wstrb  (req_wstrb),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .bank_ceb   (bank_ceb),
      .bank_web   (bank_web),
      .bank_bweb  (bank_bweb),
      .bank_a     (bank_a),
      .bank_di    (bank_di),
      .bank_do    (bank_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM banks, read data one cycle after enable.
   logic [DW-1:0] sram [NB][4096];
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!bank_ceb[b]) begin
            if (!bank_web[b])
               sram[b][bank_a[b]] <= (sram[b][bank_a[b]] & bank_bweb[b]) | (bank_di[b] & ~bank_bweb[b]);
            else
               bank_do[b] <= sram[b][bank_a[b]];
         end
      end
   end

   typedef struct {
      int           acc_cyc;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          rq[$];
   logic [DW-1:0] ref_mem [32];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   logic          prev_rst = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic we, input logic [AW-1:0] addr,
                       input logic [3:0] strb, input logic [DW-1:0] wd, input logic rr,
                       output logic accepted);
      logic          exp_rv, exp_pop, exp_rdy, acc, sel;
      logic [DW-1:0] exp_bweb;
      rsp_t          item;
      rst = r; req_valid = v; req_we = we; req_addr = addr;
      req_wstrb = strb; req_wdata = wd; resp_ready = rr;
      @(negedge clk);
      exp_rv  = (rq.size() > 0) && (rq[0].acc_cyc <= cyc - 2);
      exp_pop = exp_rv && rr;
      exp_rdy = !r && ((rq.size() - (exp_pop ? 1 : 0)) < RD);
      acc     = v && exp_rdy;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (exp_rv) chk("resp_rdata", 64'(resp_rdata), 64'(rq[0].data));
      else if (prev_rst) chk("resp_rdata_after_rst", 64'(resp_rdata), 64'd0);
      for (int k = 0; k < 4; k++) exp_bweb[k*8 +: 8] = strb[k] ? 8'h00 : 8'hFF;
      for (int b = 0; b < NB; b++) begin
         sel = acc && (!we || strb != 4'h0) && (int'(addr[1:0]) == b);
         if (sel) begin
            chk($sformatf("ceb[%0d]", b), 64'(bank_ceb[b]), 64'd0);
            chk($sformatf("web[%0d]", b), 64'(bank_web[b]), we ? 64'd0 : 64'd1);
            chk($sformatf("bweb[%0d]", b), 64'(bank_bweb[b]), we ? 64'(exp_bweb) : 64'hFFFF_FFFF);
            chk($sformatf("a[%0d]", b), 64'(bank_a[b]), 64'(addr[AW-1:2]));
            if (we) chk($sformatf("di[%0d]", b), 64'(bank_di[b]), 64'(wd));
         end else begin
            chk($sformatf("idle_ceb[%0d]", b), 64'(bank_ceb[b]), 64'd1);
            chk($sformatf("idle_web[%0d]", b), 64'(bank_web[b]), 64'd1);
            chk($sformatf("idle_bweb[%0d]", b), 64'(bank_bweb[b]), 64'hFFFF_FFFF);
            chk($sformatf("idle_a[%0d]", b), 64'(bank_a[b]), 64'd0);
            chk($sformatf("idle_di[%0d]", b), 64'(bank_di[b]), 64'd0);
         end
      end
      @(posedge clk);
      if (r) begin
         rq.delete();
      end else begin
         if (exp_pop) void'(rq.pop_front());
         if (acc) begin
            if (we) begin
               for (int k = 0; k < 4; k++)
                  if (strb[k]) ref_mem[addr[4:0]][k*8 +: 8] = wd[k*8 +: 8];
            end else begin
               item.acc_cyc = cyc;
               item.data    = ref_mem[addr[4:0]];
               rq.push_back(item);
            end
         end
      end
      prev_rst = r;
      cyc++;
      #1;
      accepted = acc;
   endtask

   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [3:0] strb,
                       input logic [DW-1:0] wd, input logic rr);
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) step(1'b0, 1'b1, we, addr, strb, wd, rr, ok);
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n, input logic rr);
      logic ok;
      for (int t = 0; t < n; t++) step(1'b0, 1'b0, 1'b0, '0, 4'h0, '0, rr, ok);
   endtask

   task automatic drain();
      logic ok;
      for (int t = 0; t < 20 && rq.size() > 0; t++) step(1'b0, 1'b0, 1'b0, '0, 4'h0, '0, 1'b1, ok);
      if (rq.size() > 0) chk("drain_timeout", 64'(rq.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic ok;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wstrb = '0; req_wdata = '0; resp_ready = 1'b1;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;

      // Reset held with a pending request.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 14'h0005, 4'h0, '0, 1'b1, ok);

      // Prefill every address used below.
      for (int i = 0; i < 32; i++) send(1'b1, AW'(i), 4'hF, $urandom, 1'b1);

      // Full write then read.
      send(1'b1, 14'h0005, 4'hF, 32'hDEADBEEF, 1'b1);
      send(1'b0, 14'h0005, 4'h0, '0, 1'b1);
      idle(3, 1'b1);

      // Byte write, read, no-op write, read.
      send(1'b1, 14'h0005, 4'b0100, 32'h00AA0000, 1'b1);
      send(1'b0, 14'h0005, 4'h0, '0, 1'b1);
      send(1'b1, 14'h0005, 4'h0, 32'h12345678, 1'b1);
      send(1'b0, 14'h0005, 4'h0, '0, 1'b1);
      drain();

      // Backpressure: third read stalls until the consumer drains.
      step(1'b0, 1'b1, 1'b0, 14'h000A, 4'h0, '0, 1'b0, ok);
      step(1'b0, 1'b1, 1'b0, 14'h000B, 4'h0, '0, 1'b0, ok);
      step(1'b0, 1'b1, 1'b0, 14'h000C, 4'h0, '0, 1'b0, ok);
      step(1'b0, 1'b1, 1'b0, 14'h000C, 4'h0, '0, 1'b0, ok);
      send(1'b0, 14'h000C, 4'h0, '0, 1'b1);
      drain();

      // Streaming reads across all banks.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, AW'(i), 4'h0, '0, 1'b1, ok);
      drain();

      // Reset with one response buffered and one read in flight.
      step(1'b0, 1'b1, 1'b0, 14'h0003, 4'h0, '0, 1'b0, ok);
      step(1'b0, 1'b1, 1'b0, 14'h0004, 4'h0, '0, 1'b0, ok);
      step(1'b1, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0, ok);
      idle(4, 1'b1);
      send(1'b0, 14'h0006, 4'h0, '0, 1'b1);
      drain();

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 31)),
              4'($urandom), $urandom, $urandom_range(0, 3) != 0, ok);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_bank_ctrl.md
Name: dm_bank_ctrl

Overview:
- Parametrised data-memory front-end between the CPU load/store port and NUM_BANKS single-port SRAM wrappers.
- Word-interleaves banks on the low address bits.
- Adds a valid/ready request channel, per-byte write strobes and a buffered, in-order read-response channel with backpressure.
- Replaces the single fixed 16K x 32 DM instance at top level.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 14, word address width.
- NUM_BANKS, 4, SRAM bank count; power of 2, at least 1.
- RESP_DEPTH, 2, response buffer depth; at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wstrb  in  DATA_W/8  byte write enables, active high
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer ready
- resp_rdata  out  DATA_W  read data
- bank_ceb  out  NUM_BANKS  per-bank chip enable, active low
- bank_web  out  NUM_BANKS  per-bank write enable, active low
- bank_bweb  out  NUM_BANKS x DATA_W  per-bank bit write enable, active low
- bank_a  out  NUM_BANKS x (ADDR_W-BSEL_W)  per-bank row address
- bank_di  out  NUM_BANKS x DATA_W  per-bank write data
- bank_do  in  NUM_BANKS x DATA_W  per-bank read data, valid 1 cycle after a read enable

Behaviour:
- Reset and clock: one clock, clk. Reset rst is synchronous and active-high.
- Address split:
  - BSEL_W = log2(NUM_BANKS).
  - bank = req_addr[BSEL_W-1:0]; row = req_addr[ADDR_W-1:BSEL_W].
  - NUM_BANKS = 1 means BSEL_W = 0 and all accesses go to bank 0.
- Accept: acc = req_valid & req_ready. Bank outputs are combinational from the request in the accept cycle.
- Idle bank outputs: ceb=1, web=1, bweb=all 1s, a=0, di=0. This applies to every bank not selected by acc.
- Write accept:
  - Selected bank: ceb=0, web=0, di=req_wdata.
  - bweb byte k = 8'h00 if req_wstrb[k], else 8'hFF.
  - No response is generated.
  - req_wstrb = 0 is accepted as a no-op: all ceb stay 1.
- Read accept:
  - Selected bank: ceb=0, web=1, bweb all 1s.
  - Register pend_v=1 and pend_bank.
  - Next cycle, bank_do[pend_bank] is pushed into the response FIFO.
  - resp_valid rises 2 cycles after the accept cycle.
- Response FIFO:
  - RESP_DEPTH entries, in order.
  - resp_valid = (count != 0); resp_rdata = head entry.
  - pop = resp_valid & resp_ready. Push and pop in the same cycle leave count unchanged.
- Flow control:
  - occ = count + pend_v - pop.
  - req_ready = !rst & (occ < RESP_DEPTH). This gates writes too, for simplicity.
  - A combinational path resp_ready -> req_ready is permitted.
  - The FIFO never overflows; an overflow is an assertion failure.
- Throughput: one request per cycle sustained when resp_ready=1.
- Ordering: requests execute in acceptance order. A read after a write to the same address in the next cycle returns the new data, because the SRAM serialises accesses.
- Reset values: resp_valid=0, resp_rdata=0, req_ready=0 while rst=1; all bank outputs at idle values; count=0, pointers=0, pend_v=0.
- Reset mid-operation: pending reads and buffered responses are discarded. No resp_valid after reset deasserts until a new read is accepted.
- Wrap-around: FIFO pointers wrap modulo RESP_DEPTH. RESP_DEPTH need not be a power of 2, so use an explicit wrap compare.

Decomposition:
- Package dm_pkg:
  - Function for the bank-select width (log2 with minimum 0).
  - Function for byte-strobe to BWEB expansion.
  - Idle-bank constant values.
- Sub-module resp_fifo (parametrised DATA_W, DEPTH):
  - Synchronous-reset circular buffer with push, pop, count, head data.
- Top-level integration: replace DM1 with NUM_BANKS SRAM_wrapper instances fed by bank_* signals.

Test Plan (NUM_BANKS=4, DATA_W=32, ADDR_W=14, RESP_DEPTH=2):
1. Reset:
   - Stimulus: rst=1 for 3 cycles with req_valid=1.
   - Response: req_ready=0, bank_ceb=4'b1111, resp_valid=0; req_ready=1 in the first cycle after rst falls.
2. Full write then read:
   - Stimulus: write addr 0x0005, data 0xDEADBEEF, strb 4'hF.
   - Response: bank 1 ceb=0, web=0, a=0x001, bweb=0x00000000.
   - Stimulus: read 0x0005 accepted at cycle T.
   - Response: resp_valid at T+2 with 0xDEADBEEF.
3. Byte write:
   - Stimulus: write 0x0005, data 0x00AA0000, strb 4'b0100.
   - Response: bweb=0xFF00FFFF; a following read returns 0xDEAABEEF.
   - Stimulus: strb=0 write.
   - Response: accepted, all ceb=1, memory unchanged.
4. Backpressure:
   - Stimulus: resp_ready=0, three back-to-back reads.
   - Response: first two accepted, then req_ready=0 and the third stalls.
   - Stimulus: resp_ready=1.
   - Response: three responses in order, no loss or duplication.
5. Streaming:
   - Stimulus: resp_ready=1, reads of addresses 0..7 back to back after prefill.
   - Response: accept every cycle, banks rotate 0,1,2,3,0..., data returned in order at latency 2.
6. Reset mid-operation:
   - Stimulus: one read pending and one buffered, then rst for 1 cycle.
   - Response: resp_valid stays 0 afterwards; a new read then returns correct data.
